// File: rtl/codec_tx_serializer_if.sv
// Sample-pair handshake from the equalizer core into the I2S transmitter.
// The core drives a left/right pair with valid; the transmitter answers with ready.
interface codec_tx_serializer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] lft_in;
    logic [DATA_W-1:0] rht_in;
    logic              valid;
    logic              ready;

    modport master (
        output lft_in,
        output rht_in,
        output valid,
        input  ready
    );

    modport slave (
        input  lft_in,
        input  rht_in,
        input  valid,
        output ready
    );
endinterface

// File: rtl/codec_tx_serializer.sv
// Stereo I2S transmitter: double-buffers sample pairs and shifts them MSB-first
// onto SDout, one SCLK after each LRCLK edge, with flop-derived SCLK/LRCLK.
module codec_tx_serializer #(
    parameter int DATA_W    = 16,
    parameter int SCLK_LOG2 = 4,
    parameter int SLOT_LOG2 = 5
) (
    input  logic clk,
    input  logic rst,
    codec_tx_serializer_if.slave bus,
    output logic SCLK,
    output logic LRCLK,
    output logic SDout,
    output logic underrun
);
    localparam int N = SCLK_LOG2 + SLOT_LOG2 + 1;

    logic [N-1:0]         cnt;
    logic [N-1:0]         cnt_nx;
    logic [DATA_W-1:0]    hold_l;
    logic [DATA_W-1:0]    hold_r;
    logic [DATA_W-1:0]    tx_l;
    logic [DATA_W-1:0]    tx_r;
    logic [DATA_W-1:0]    next_l;
    logic [DATA_W-1:0]    next_r;
    logic [DATA_W-1:0]    word;
    logic [SLOT_LOG2-1:0] k_nx;
    logic                 full;
    logic                 frame_end;
    logic                 bit_end;
    logic                 accept;
    logic                 load_hold;
    logic                 load_bypass;
    logic                 sd_nx;

    assign cnt_nx      = cnt + N'(1);
    assign frame_end   = &cnt;
    assign bit_end     = &cnt[SCLK_LOG2-1:0];
    assign load_hold   = frame_end & full;
    assign load_bypass = frame_end & ~full & bus.valid;
    // A pair arriving on the load cycle goes straight to the shifter instead.
    assign accept      = bus.valid & ~full & ~frame_end;
    assign underrun    = frame_end & ~full & ~bus.valid;
    assign bus.ready   = ~full;
    assign SCLK        = cnt[SCLK_LOG2-1];
    assign LRCLK       = cnt[N-1];

    always_comb begin
        next_l = tx_l;
        next_r = tx_r;
        unique case (1'b1)
            load_hold: begin
                next_l = hold_l;
                next_r = hold_r;
            end
            load_bypass: begin
                next_l = bus.lft_in;
                next_r = bus.rht_in;
            end
            default: ;
        endcase
    end

    // Bit for the slot position about to start; slot bit 0 is the I2S delay bit.
    assign k_nx = cnt_nx[N-2:SCLK_LOG2];
    assign word = cnt_nx[N-1] ? tx_r : tx_l;

    always_comb begin
        sd_nx = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(k_nx) == DATA_W - i) sd_nx = word[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            hold_l <= '0;
            hold_r <= '0;
            tx_l   <= '0;
            tx_r   <= '0;
            full   <= 1'b0;
            SDout  <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            tx_l <= next_l;
            tx_r <= next_r;
            if (accept) begin
                hold_l <= bus.lft_in;
                hold_r <= bus.rht_in;
                full   <= 1'b1;
            end else if (load_hold) begin
                full <= 1'b0;
            end
            if (bit_end) SDout <= sd_nx;
        end
    end
endmodule

// File: tb/tb_codec_tx_serializer.sv
// Bench for codec_tx_serializer: frame scoreboard fed by the test tasks,
// compared against bits captured on SCLK rising edges.
module tb_codec_tx_serializer;
    typedef struct {
        int          frame;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic SCLK;
    logic LRCLK;
    logic SDout;
    logic underrun;
    logic [9:0] tcnt;
    int checks = 0;
    int errors = 0;
    int fidx = 0;
    exp_t q[$];

    codec_tx_serializer_if #(.DATA_W(16)) bus ();

    codec_tx_serializer #(
        .DATA_W(16),
        .SCLK_LOG2(4),
        .SLOT_LOG2(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .SCLK(SCLK),
        .LRCLK(LRCLK),
        .SDout(SDout),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tcnt <= '0;
        else tcnt <= tcnt + 10'd1;
    end

    task automatic push(input int f, input logic [15:0] l,
                        input logic [15:0] r);
        exp_t e;
        e.frame = f;
        e.l = l;
        e.r = r;
        q.push_back(e);
    endtask

    task automatic goto(input int v);
        for (int n = 0; n < 1100; n++) begin
            @(posedge clk);
            #1;
            if (int'(tcnt) == v) return;
        end
        errors++;
        $display("FAIL goto cnt %0d never reached", v);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bus.lft_in = l;
        bus.rht_in = r;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic monitor();
        logic [31:0] cap_l;
        logic [31:0] cap_r;
        logic started;
        exp_t e;
        started = 1'b0;
        cap_l = '0;
        cap_r = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                started = 1'b0;
                fidx = 0;
                continue;
            end
            checks++;
            if (SCLK !== tcnt[3] || LRCLK !== tcnt[9]) begin
                errors++;
                $display("FAIL clocks cnt=%0d got %b%b want %b%b",
                         tcnt, SCLK, LRCLK, tcnt[3], tcnt[9]);
            end
            if (tcnt == 10'd0) begin
                started = 1'b1;
                cap_l = '0;
                cap_r = '0;
            end
            if (tcnt[3:0] == 4'd8) begin
                if (tcnt[9]) cap_r[5'd31 - tcnt[8:4]] = SDout;
                else cap_l[5'd31 - tcnt[8:4]] = SDout;
            end
            if (tcnt == 10'd1023 && started) begin
                while (q.size() > 0 && q[0].frame <= fidx) begin
                    e = q.pop_front();
                    checks++;
                    if (e.frame != fidx || cap_l !== {1'b0, e.l, 15'b0}) begin
                        errors++;
                        $display("FAIL left frame %0d got %h want %h",
                                 e.frame, cap_l, {1'b0, e.l, 15'b0});
                    end
                    checks++;
                    if (e.frame != fidx || cap_r !== {1'b0, e.r, 15'b0}) begin
                        errors++;
                        $display("FAIL right frame %0d got %h want %h",
                                 e.frame, cap_r, {1'b0, e.r, 15'b0});
                    end
                end
                fidx++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({SCLK, LRCLK, SDout, underrun, bus.ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00001",
                     {SCLK, LRCLK, SDout, underrun, bus.ready});
        end
        push(0, 16'h0000, 16'h0000);
        rst = 1'b0;
    endtask

    task automatic test_single();
        goto(200);
        push(fidx + 1, 16'hA5C3, 16'h8001);
        send(16'hA5C3, 16'h8001);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_fall got %b want 0", bus.ready);
        end
        goto(1023);
        checks++;
        if (bus.ready !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL full_at_end got %b%b want 00",
                     bus.ready, underrun);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise got %b want 1", bus.ready);
        end
    endtask

    task automatic test_underrun();
        int pulses;
        int pos;
        pulses = 0;
        pos = -1;
        push(fidx + 1, 16'hA5C3, 16'h8001);
        repeat (1024) begin
            if (underrun === 1'b1) begin
                pulses++;
                pos = int'(tcnt);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses != 1 || pos != 1023) begin
            errors++;
            $display("FAIL underrun_pulse got %0d at %0d want 1 at 1023",
                     pulses, pos);
        end
    endtask

    task automatic test_overflow();
        goto(100);
        push(fidx + 1, 16'h1234, 16'h5678);
        send(16'h1234, 16'h5678);
        goto(300);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_ready got %b want 0", bus.ready);
        end
        send(16'h9ABC, 16'hDEF0);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_ready2 got %b want 0", bus.ready);
        end
        goto(1023);
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        goto(1023);
        bus.lft_in = 16'h7FFF;
        bus.rht_in = 16'h0001;
        bus.valid = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL bypass_end got %b%b want 10",
                     bus.ready, underrun);
        end
        push(fidx + 1, 16'h7FFF, 16'h0001);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready got %b want 1", bus.ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            goto(100);
            push(fidx + 1, 16'h0100 + 16'(i), 16'hF0F0 ^ 16'(i));
            send(16'h0100 + 16'(i), 16'hF0F0 ^ 16'(i));
            goto(1023);
            checks++;
            if (underrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_underrun %0d got %b want 0", i, underrun);
            end
            @(posedge clk);
            #1;
        end
        goto(1023);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail_underrun got %b want 1", underrun);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_midframe_reset();
        goto(100);
        send(16'h4444, 16'h2222);
        goto(700);
        checks++;
        if (bus.ready !== 1'b0 || SDout !== 1'b1 || SCLK !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got %b%b%b want 011",
                     bus.ready, SDout, SCLK);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({SCLK, LRCLK, SDout, underrun, bus.ready} !== 5'b00001) begin
            errors++;
            $display("FAIL async_reset got %b want 00001",
                     {SCLK, LRCLK, SDout, underrun, bus.ready});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 16'h0000, 16'h0000);
        push(1, 16'h0000, 16'h0000);
        goto(1023);
        checks++;
        if (underrun !== 1'b1 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_end got %b%b want 11",
                     underrun, bus.ready);
        end
        @(posedge clk);
        #1;
        goto(1023);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.valid = 1'b0;
        bus.lft_in = '0;
        bus.rht_in = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_underrun();
        test_overflow();
        test_bypass();
        test_back_to_back();
        test_midframe_reset();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
